sram_controller: RTL and testbench

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_controller_if.sv | 20 ++
 rtl/sram_controller.sv | 158 +++++++++++++++
 tb/tb_sram_controller.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/sram_controller_if.sv
// Requester-side bus of the SRAM controller: MEM-stage load/store request and result.
// The master modport is the pipeline side; the slave modport is the controller.
interface sram_controller_if;
    logic [31:0] address;
    logic [31:0] WriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] ReadData;
    logic        ready;

    modport master (
        output address, WriteData, MemRead, MemWrite,
        input  ReadData, ready
    );

    modport slave (
        input  address, WriteData, MemRead, MemWrite,
        output ReadData, ready
    );
endinterface

// File: rtl/sram_controller.sv
// 32-bit load/store front end for a 16-bit asynchronous SRAM: two half-word accesses then a wait.
// Optional macro READ_BYPASS_EN adds a one-entry buffer that answers repeat reads in IDLE.
module sram_controller #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    sram_controller_if.slave    bus,
    inout  wire  [15:0]         SRAM_DQ,
    output logic [17:0]         SRAM_ADDR,
    output logic                SRAM_WE_N,
    output logic                SRAM_CE_N,
    output logic                SRAM_OE_N,
    output logic                SRAM_UB_N,
    output logic                SRAM_LB_N
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LO   = 3'd1,
        HI   = 3'd2,
        WAIT = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_wait_cnt;
    logic        r_is_write;
    logic [16:0] r_index;
    logic [31:0] r_wdata;
    logic [31:0] r_read_data;

    logic [31:0] w_diff;
    logic [16:0] w_index;
    logic        w_hit;
    logic        w_start;
    logic        w_dq_oe;
    logic [15:0] w_dq_out;
    logic        w_unused;

    // Data memory starts at byte 1024; the byte offset within a word is dropped.
    assign w_diff   = bus.address - 32'd1024;
    assign w_index  = w_diff[18:2];
    assign w_unused = &{1'b0, w_diff[31:19], w_diff[1:0]};

`ifdef READ_BYPASS_EN
    logic        r_byp_valid;
    logic [16:0] r_byp_index;
    logic [31:0] r_byp_data;

    assign w_hit = (r_state == IDLE) && bus.MemRead && !bus.MemWrite &&
                   r_byp_valid && (w_index == r_byp_index);
    assign bus.ReadData = w_hit ? r_byp_data : r_read_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_byp_valid <= 1'b0;
            r_byp_index <= '0;
            r_byp_data  <= '0;
        end else if (r_state == DONE) begin
            if (!r_is_write) begin
                r_byp_valid <= 1'b1;
                r_byp_index <= r_index;
                r_byp_data  <= r_read_data;
            end else if (r_byp_valid && (r_index == r_byp_index)) begin
                r_byp_data  <= r_wdata;
            end
        end
    end
`else
    assign w_hit        = 1'b0;
    assign bus.ReadData = r_read_data;
`endif

    assign w_start = (bus.MemRead || bus.MemWrite) && !w_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_wait_cnt  <= '0;
            r_is_write  <= 1'b0;
            r_index     <= '0;
            r_wdata     <= '0;
            r_read_data <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    // Request is captured once so later input changes cannot disturb the access.
                    if (w_start) begin
                        r_index    <= w_index;
                        r_wdata    <= bus.WriteData;
                        r_is_write <= bus.MemWrite;
                    end
                    if (w_hit) begin
                        r_read_data <= bus.ReadData;
                    end
                end
                LO: begin
                    if (!r_is_write) begin
                        r_read_data[15:0] <= SRAM_DQ;
                    end
                end
                HI: begin
                    r_wait_cnt <= '0;
                    if (!r_is_write) begin
                        r_read_data[31:16] <= SRAM_DQ;
                    end
                end
                WAIT: begin
                    r_wait_cnt <= r_wait_cnt + 4'd1;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        bus.ready    = 1'b0;
        case (r_state)
            IDLE: begin
                bus.ready = w_hit || (!bus.MemRead && !bus.MemWrite);
                if (w_start) begin
                    w_state_next = LO;
                end
            end
            LO:   w_state_next = HI;
            HI:   w_state_next = WAIT;
            WAIT: begin
                if (r_wait_cnt == WAIT_LAST) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                bus.ready    = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_dq_oe   = r_is_write && ((r_state == LO) || (r_state == HI));
    assign w_dq_out  = (r_state == HI) ? r_wdata[31:16] : r_wdata[15:0];
    assign SRAM_DQ   = w_dq_oe ? w_dq_out : 16'bz;
    assign SRAM_WE_N = !w_dq_oe;
    assign SRAM_ADDR = {r_index, (r_state == HI)};

    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a behavioural 16-bit SRAM on the data bus.
// Expected values are hand-computed for WAIT_CYCLES=2 (ready in cycle 5).
module tb_sram_controller;

    logic        clk;
    logic        rst;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        we_n, ce_n, oe_n, ub_n, lb_n;
    logic [15:0] mem [0:255];

    int n_checks = 0;
    int n_errors = 0;

    sram_controller_if bus ();

    sram_controller #(.WAIT_CYCLES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .SRAM_DQ   (sram_dq),
        .SRAM_ADDR (sram_addr),
        .SRAM_WE_N (we_n),
        .SRAM_CE_N (ce_n),
        .SRAM_OE_N (oe_n),
        .SRAM_UB_N (ub_n),
        .SRAM_LB_N (lb_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: drives the bus whenever not being written.
    assign sram_dq = we_n ? mem[sram_addr[7:0]] : 16'hzzzz;
    always @(posedge clk) begin
        if (!we_n) mem[sram_addr[7:0]] <= sram_dq;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Caller is at posedge+1 (start of cycle 0); returns at start of the cycle after ready.
    task automatic xact(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic rd, input logic wr, input int rdy_cyc,
                        input logic [17:0] lo_addr, input logic [31:0] exp_rd);
        bus.address   = addr;
        bus.WriteData = wdata;
        bus.MemRead   = rd;
        bus.MemWrite  = wr;
        for (int cyc = 0; cyc <= rdy_cyc; cyc++) begin
            @(negedge clk);
            check($sformatf("%s ready c%0d", tag, cyc), 32'(bus.ready), 32'(cyc == rdy_cyc));
            if (cyc == 1) begin
                check({tag, " we_n LO"}, 32'(we_n), 32'(!wr));
                check({tag, " addr LO"}, 32'(sram_addr), 32'(lo_addr));
                if (wr) check({tag, " dq LO"}, 32'(sram_dq), 32'(wdata[15:0]));
            end
            if (cyc == 2) begin
                check({tag, " addr HI"}, 32'(sram_addr), 32'(lo_addr) + 32'd1);
                if (wr) check({tag, " dq HI"}, 32'(sram_dq), 32'(wdata[31:16]));
            end
            if (cyc == 3) check({tag, " we_n WAIT"}, 32'(we_n), 32'd1);
            if (cyc == rdy_cyc) check({tag, " ReadData"}, bus.ReadData, exp_rd);
            @(posedge clk);
            #1;
        end
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        $display("xact %s addr=%h wdata=%h rd=%0b wr=%0b ReadData=%h", tag, addr, wdata, rd, wr,
                 bus.ReadData);
    endtask

    initial begin
        rst           = 1'b1;
        bus.address   = '0;
        bus.WriteData = '0;
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle after reset
        @(negedge clk);
        check("idle ready", 32'(bus.ready), 32'd1);
        check("idle ReadData", bus.ReadData, 32'd0);
        check("idle we_n", 32'(we_n), 32'd1);
        check("tied strobes", 32'({ce_n, oe_n, ub_n, lb_n}), 32'd0);
        $display("xact idle ready=%0b ReadData=%h", bus.ready, bus.ReadData);
        @(posedge clk);
        #1;

        // Write 1028 then back-to-back readback
        xact("write1028", 32'd1028, 32'h12345678, 1'b0, 1'b1, 5, 18'd2, 32'd0);
        check("mem[2]", 32'(mem[2]), 32'h0000_5678);
        check("mem[3]", 32'(mem[3]), 32'h0000_1234);
        xact("read1028", 32'd1028, 32'h0, 1'b1, 1'b0, 5, 18'd2, 32'h12345678);

`ifdef READ_BYPASS_EN
        xact("reread1028", 32'd1028, 32'h0, 1'b1, 1'b0, 0, 18'd2, 32'h12345678);
`else
        xact("reread1028", 32'd1028, 32'h0, 1'b1, 1'b0, 5, 18'd2, 32'h12345678);
`endif

        // Read+write conflict resolves to a write, ReadData untouched
        repeat (2) @(posedge clk);
        #1;
        xact("conflict1032", 32'd1032, 32'hAABBCCDD, 1'b1, 1'b1, 5, 18'd4, 32'h12345678);
        check("mem[4]", 32'(mem[4]), 32'h0000_CCDD);
        check("mem[5]", 32'(mem[5]), 32'h0000_AABB);

        // Reset during cycle 2 of a read aborts it
        bus.address = 32'd1032;
        bus.MemRead = 1'b1;
        @(negedge clk);
        check("abort ready c0", 32'(bus.ready), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("abort ready c1", 32'(bus.ready), 32'd0);
        @(posedge clk);
        #1;
        rst         = 1'b1;
        bus.MemRead = 1'b0;
        @(negedge clk);
        check("abort ready c2", 32'(bus.ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort idle ready", 32'(bus.ready), 32'd1);
        check("abort ReadData", bus.ReadData, 32'd0);
        check("abort we_n", 32'(we_n), 32'd1);
        $display("xact abort ready=%0b ReadData=%h", bus.ready, bus.ReadData);
        @(posedge clk);
        #1;

        xact("read1032", 32'd1032, 32'h0, 1'b1, 1'b0, 5, 18'd4, 32'hAABBCCDD);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
